inst_fetch: RTL and testbench

Upstream fetch stage for the 8-bit step processor. It holds a small loadable program memory and a program counter, and debounces the board's raw step button. On each clean press it fetches the next instruction and presents it, with its address and a one-cycle valid strobe, to the downstream execute stage. It replaces free-running level-sensitive stepping with exactly one fetch per physical press.

---
 rtl/inst_fetch_pkg.sv | 14 +
 rtl/step_debounce.sv | 57 +++++
 rtl/inst_fetch.sv | 108 ++++++++++
 tb/tb_inst_fetch.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared constants and FSM encoding for the fetch stage
package inst_fetch_pkg;

    // Default widths shared with the execute stage
    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/step_debounce.sv
// rtl/step_debounce.sv - synchronise, debounce and rising-edge detect the step button
module step_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic pulse_out
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             step_sync;
    logic [CNT_W-1:0] count;
    logic             stable_level;
    logic             stable_prev;

    // Two-flop synchroniser for the asynchronous button input
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1    <= 1'b0;
            step_sync <= 1'b0;
        end else begin
            sync_1    <= raw_in;
            step_sync <= sync_1;
        end
    end

    // Accept a level change only after it has held for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count        <= '0;
            stable_level <= 1'b0;
        end else if (step_sync == stable_level) begin
            count <= '0;
        end else if (count == CNT_LAST) begin
            stable_level <= ~stable_level;
            count        <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // Registered one-cycle pulse on a debounced press (release is ignored)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_prev <= 1'b0;
            pulse_out   <= 1'b0;
        end else begin
            stable_prev <= stable_level;
            pulse_out   <= stable_level & ~stable_prev;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - one instruction fetch per debounced step press
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int DATA_W          = DATA_W_DEF,
    parameter int ADDR_W          = ADDR_W_DEF,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int RESET_PC        = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step_raw,
    input  logic              halt,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] instruction,
    output logic              inst_valid
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

    fetch_state_t      state;
    fetch_state_t      next_state;
    logic              step_pulse;
    logic              do_fetch;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] mem [DEPTH];

    step_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_debounce (
        .clk      (clk),
        .reset    (reset),
        .raw_in   (step_raw),
        .pulse_out(step_pulse)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state; presses arriving outside IDLE or while halted are dropped
    always_comb begin
        next_state = state;
        do_fetch   = 1'b0;
        inst_valid = 1'b0;
        case (state)
            IDLE: begin
                if (step_pulse && !halt) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                do_fetch   = 1'b1;
                next_state = ISSUE;
            end
            ISSUE: begin
                inst_valid = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Write-first read so a same-cycle load to the fetched address is seen
    always_comb begin
        read_data = mem[pc];
        if (load_en && (load_addr == pc)) begin
            read_data = load_data;
        end
    end

    // Program memory writes, allowed in any state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    // Fetch datapath: capture instruction and address, advance pc with wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= PC_INIT;
            address     <= PC_INIT;
            instruction <= '0;
        end else if (do_fetch) begin
            instruction <= read_data;
            address     <= pc;
            pc          <= pc + 1'b1;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed self-checking bench for inst_fetch
`timescale 1ns/1ps
module tb_inst_fetch;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       step_raw = 1'b0;
    logic       halt = 1'b0;
    logic       load_en = 1'b0;
    logic [1:0] load_addr = '0;
    logic [7:0] load_data = '0;
    logic [1:0] address;
    logic [7:0] instruction;
    logic       inst_valid;

    int passed = 0;
    int total = 0;
    int vcount = 0;
    int cyc = 0;
    int last_cyc = 0;
    int rise_cyc = 0;
    int base;
    logic [7:0] last_inst = '0;
    logic [1:0] last_addr = '0;

    logic [7:0] prog [4];
    logic [7:0] wrap_inst [5];
    logic [1:0] wrap_addr [5];

    inst_fetch #(
        .DATA_W(8),
        .ADDR_W(2),
        .DEBOUNCE_CYCLES(16),
        .RESET_PC(0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .step_raw   (step_raw),
        .halt       (halt),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .address    (address),
        .instruction(instruction),
        .inst_valid (inst_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (inst_valid) begin
            vcount    = vcount + 1;
            last_inst = instruction;
            last_addr = address;
            last_cyc  = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic load_word(input logic [1:0] a, input logic [7:0] d);
        @(posedge clk); #2;
        load_en = 1'b1; load_addr = a; load_data = d;
        @(posedge clk); #2;
        load_en = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
    endtask

    task automatic press();
        @(posedge clk); #2;
        step_raw = 1'b1;
        repeat (40) @(posedge clk);
        #2 step_raw = 1'b0;
        repeat (40) @(posedge clk);
    endtask

    task automatic load_prog();
        for (int i = 0; i < 4; i++) load_word(2'(i), prog[i]);
    endtask

    initial begin
        prog[0] = 8'hA1; prog[1] = 8'hB2; prog[2] = 8'hC3; prog[3] = 8'hD4;
        wrap_inst[0] = 8'hA1; wrap_inst[1] = 8'hB2; wrap_inst[2] = 8'hC3;
        wrap_inst[3] = 8'hD4; wrap_inst[4] = 8'hA1;
        wrap_addr[0] = 2'd0; wrap_addr[1] = 2'd1; wrap_addr[2] = 2'd2;
        wrap_addr[3] = 2'd3; wrap_addr[4] = 2'd0;

        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("reset_addr", 32'(address), 32'h0);
        check("reset_inst", 32'(instruction), 32'h0);
        check("reset_valid", 32'(inst_valid), 32'h0);

        // 1. async reset mid-run clears outputs and memory
        load_word(2'd0, 8'h77);
        press();
        check("t1_pre_inst", 32'(last_inst), 32'h77);
        press();
        check("t1_pre_addr", 32'(address), 32'h1);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check("t1_async_addr", 32'(address), 32'h0);
        check("t1_async_inst", 32'(instruction), 32'h0);
        check("t1_async_valid", 32'(inst_valid), 32'h0);
        @(posedge clk); #2 reset = 1'b0;
        base = vcount;
        press();
        check("t1_post_count", 32'(vcount - base), 32'h1);
        check("t1_post_inst", 32'(last_inst), 32'h0);
        check("t1_post_addr", 32'(last_addr), 32'h0);

        // 2. load program, single press, latency
        do_reset();
        load_prog();
        base = vcount;
        @(posedge clk); #2;
        rise_cyc = cyc;
        step_raw = 1'b1;
        repeat (40) @(posedge clk);
        check("t2_count", 32'(vcount - base), 32'h1);
        check("t2_inst", 32'(last_inst), 32'hA1);
        check("t2_addr", 32'(last_addr), 32'h0);
        check("t2_latency", 32'(last_cyc - rise_cyc), 32'd21);
        #2 step_raw = 1'b0;
        repeat (40) @(posedge clk);
        check("t2_release_count", 32'(vcount - base), 32'h1);

        // 3. bounce on press and release yields one fetch
        base = vcount;
        for (int i = 0; i < 10; i++) begin
            #2 step_raw = ~step_raw;
            repeat (3) @(posedge clk);
        end
        #2 step_raw = 1'b1;
        repeat (40) @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            #2 step_raw = ~step_raw;
            repeat (3) @(posedge clk);
        end
        #2 step_raw = 1'b0;
        repeat (40) @(posedge clk);
        check("t3_count", 32'(vcount - base), 32'h1);
        check("t3_inst", 32'(last_inst), 32'hB2);
        check("t3_addr", 32'(last_addr), 32'h1);

        // 4. wrap across the end of memory
        do_reset();
        load_prog();
        for (int i = 0; i < 5; i++) begin
            base = vcount;
            press();
            check("t4_count", 32'(vcount - base), 32'h1);
            check("t4_inst", 32'(last_inst), 32'(wrap_inst[i]));
            check("t4_addr", 32'(last_addr), 32'(wrap_addr[i]));
        end

        // 5. halt discards the press without advancing pc
        halt = 1'b1;
        base = vcount;
        press();
        check("t5_halt_count", 32'(vcount - base), 32'h0);
        check("t5_halt_addr_hold", 32'(address), 32'h0);
        halt = 1'b0;
        press();
        check("t5_resume_count", 32'(vcount - base), 32'h1);
        check("t5_resume_inst", 32'(last_inst), 32'hB2);
        check("t5_resume_addr", 32'(last_addr), 32'h1);

        // 6. same-cycle load during FETCH is write-first
        do_reset();
        load_prog();
        press();
        check("t6_first_inst", 32'(last_inst), 32'hA1);
        base = vcount;
        @(posedge clk); #2;
        step_raw = 1'b1;
        repeat (20) @(posedge clk);
        #2 load_en = 1'b1; load_addr = 2'd1; load_data = 8'h5E;
        @(posedge clk); #2 load_en = 1'b0;
        repeat (20) @(posedge clk);
        #2 step_raw = 1'b0;
        repeat (40) @(posedge clk);
        check("t6_coll_count", 32'(vcount - base), 32'h1);
        check("t6_coll_inst", 32'(last_inst), 32'h5E);
        check("t6_coll_addr", 32'(last_addr), 32'h1);

        // reset during FETCH aborts the fetch and returns pc to 0
        base = vcount;
        @(posedge clk); #2;
        step_raw = 1'b1;
        repeat (20) @(posedge clk);
        #2 reset = 1'b1; step_raw = 1'b0;
        @(posedge clk); #2 reset = 1'b0;
        repeat (40) @(posedge clk);
        check("t6_abort_count", 32'(vcount - base), 32'h0);
        load_word(2'd0, 8'h11);
        load_word(2'd2, 8'h22);
        press();
        check("t6_after_count", 32'(vcount - base), 32'h1);
        check("t6_after_inst", 32'(last_inst), 32'h11);
        check("t6_after_addr", 32'(last_addr), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
